// File: rtl/gcd_stream.sv
// gcd_stream: ready/valid GCD engine (subtractive Euclid or binary Stein, chosen at
// elaboration) returning gcd(a,b) and a saturating count of RUN cycles.
module gcd_stream #(
  parameter int W      = 16,
  parameter int CW     = 8,
  parameter int BINARY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [W-1:0]  io_in_a,
  input  logic [W-1:0]  io_in_b,
  output logic          io_out_valid,
  input  logic          io_out_ready,
  output logic [W-1:0]  io_out_z,
  output logic [CW-1:0] io_out_cycles
);

  localparam int KW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  z_q, z_d;
  logic [CW-1:0] cycles_q, cycles_d;

  logic [CW-1:0] cnt_inc;
  logic [W-1:0]  x_minus_y;
  logic [W-1:0]  y_minus_x;

  assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
  assign x_minus_y = x_q - y_q;
  assign y_minus_x = y_q - x_q;

  // One reduction step per RUN cycle; the zero test comes first, so termination costs a cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (io_in_valid) begin
          x_d     = io_in_a;
          y_d     = io_in_b;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (x_q == '0 || y_q == '0) begin
          z_d      = (x_q | y_q) << k_q;
          cycles_d = cnt_inc;
          state_d  = S_DONE;
        end else if (BINARY == 0) begin
          if (x_q > y_q) x_d = x_minus_y;
          else           y_d = y_minus_x;
        end else begin
          // k counts the common factors of two restored by the final shift.
          if (!x_q[0] && !y_q[0]) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + KW'(1);
          end else if (!x_q[0]) begin
            x_d = x_q >> 1;
          end else if (!y_q[0]) begin
            y_d = y_q >> 1;
          end else if (x_q >= y_q) begin
            x_d = x_minus_y >> 1;
          end else begin
            y_d = y_minus_x >> 1;
          end
        end
      end
      S_DONE: begin
        if (io_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      cycles_q <= cycles_d;
    end
  end

  assign io_in_ready   = (state_q == S_IDLE);
  assign io_out_valid  = (state_q == S_DONE);
  assign io_out_z      = z_q;
  assign io_out_cycles = cycles_q;

endmodule
